// File: rtl/dcpu_pkg.sv
// rtl/dcpu_pkg.sv - opcode constants, flag indices and CF-update decode shared by the datapath
package dcpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDC = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SUBC = 4'b0011;
    localparam logic [3:0] OP_INC  = 4'b0100;
    localparam logic [3:0] OP_DEC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_CMP  = 4'b0111;
    localparam logic [3:0] OP_TRAN = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_SLL  = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1101;
    localparam logic [3:0] OP_ROL  = 4'b1110;
    localparam logic [3:0] OP_SRA  = 4'b1111;

    localparam int FLG_CF = 2;
    localparam int FLG_ZF = 1;
    localparam int FLG_NF = 0;

    // CMP and the logical group 10xx leave the carry untouched so ADDC/SUBC chains survive them
    function automatic logic updates_cf(input logic [3:0] opc);
        return !((opc == OP_CMP) || (opc[3:2] == 2'b10));
    endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// rtl/alu_writeback_stage_if.sv - ALU result intake and register-file writeback handshakes
interface alu_writeback_stage_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          in_vld;
    logic          in_rdy;
    logic [3:0]    opc;
    logic [DW-1:0] res;
    logic          rcf;
    logic          rzf;
    logic          rnf;
    logic          wen;
    logic [AW-1:0] dst;
    logic          wb_vld;
    logic          wb_rdy;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    modport master (
        output in_vld, opc, res, rcf, rzf, rnf, wen, dst, wb_rdy,
        input  in_rdy, wb_vld, wb_addr, wb_data
    );

    modport slave (
        input  in_vld, opc, res, rcf, rzf, rnf, wen, dst, wb_rdy,
        output in_rdy, wb_vld, wb_addr, wb_data
    );
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small power-of-two FIFO holding pending register-file writes
module wb_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_en;
    logic          pop_en;

    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - captures ALU flags, feeds CF back, queues register writes
module alu_writeback_stage
    import dcpu_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_writeback_stage_if.slave  bus,
    output logic                  icf,
    output logic [2:0]            flags
);
    logic             cf;
    logic             zf;
    logic             nf;
    logic             accept;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [AW+DW-1:0] head;

    assign accept = bus.in_vld & bus.in_rdy;
    assign push   = accept & bus.wen & (bus.opc != OP_CMP);
    assign pop    = bus.wb_vld & bus.wb_rdy;

    // a full queue blocks flag-only opcodes too, keeping flag order in program order
    assign bus.in_rdy = ~full;
    assign bus.wb_vld = ~empty;
    assign {bus.wb_addr, bus.wb_data} = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cf <= 1'b0;
            zf <= 1'b0;
            nf <= 1'b0;
        end else if (accept) begin
            zf <= bus.rzf;
            nf <= bus.rnf;
            if (updates_cf(bus.opc)) begin
                cf <= bus.rcf;
            end
        end
    end

    assign icf = cf;

    always_comb begin
        flags         = '0;
        flags[FLG_CF] = cf;
        flags[FLG_ZF] = zf;
        flags[FLG_NF] = nf;
    end

    wb_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.dst, bus.res}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

endmodule
